// File: rtl/mci_arbiter.sv
// Two-port arbiter sharing one memory-controller port between icache (port 0) and dcache (port 1).
// Optional MCI_ARB_ROUND_ROBIN_EN selects round-robin on contention; default is fixed port-1 priority.
module mci_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic              req0_rw_i,
    input  logic              req0_valid_i,
    output logic [DATA_W-1:0] res0_data_o,
    output logic              res0_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic              req1_rw_i,
    input  logic              req1_valid_i,
    output logic [DATA_W-1:0] res1_data_o,
    output logic              res1_ready_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    output logic              mem_req_rw_o,
    output logic              mem_req_valid_o,
    input  logic [DATA_W-1:0] mem_res_data_i,
    input  logic              mem_res_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              pend0_q, pend0_d, pend1_q, pend1_d;
    logic [ADDR_W-1:0] addr0_q, addr1_q;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic              rw0_q, rw1_q;
    logic              sel;
    logic              cap0, cap1;

    // grant_q doubles as the last-grant pointer in round-robin mode
    always_comb begin
`ifdef MCI_ARB_ROUND_ROBIN_EN
        if (pend0_q && pend1_q) begin
            sel = ~grant_q;
        end else begin
            sel = pend1_q;
        end
`else
        sel = pend1_q;
`endif
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        mem_req_rw_o    = 1'b0;
        res0_ready_o    = 1'b0;
        res0_data_o     = '0;
        res1_ready_o    = 1'b0;
        res1_data_o     = '0;
        case (state_q)
            IDLE: begin
                if (pend0_q || pend1_q) begin
                    mem_req_valid_o = 1'b1;
                    mem_req_addr_o  = sel ? addr1_q : addr0_q;
                    mem_req_data_o  = sel ? data1_q : data0_q;
                    mem_req_rw_o    = sel ? rw1_q : rw0_q;
                    grant_d         = sel;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                mem_req_addr_o = grant_q ? addr1_q : addr0_q;
                mem_req_data_o = grant_q ? data1_q : data0_q;
                mem_req_rw_o   = grant_q ? rw1_q : rw0_q;
                if (mem_res_ready_i) begin
                    if (grant_q) begin
                        res1_ready_o = 1'b1;
                        res1_data_o  = mem_res_data_i;
                    end else begin
                        res0_ready_o = 1'b1;
                        res0_data_o  = mem_res_data_i;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request arriving with its own ready is accepted so a follow-on fill is not lost
    assign cap0    = req0_valid_i && (!pend0_q || res0_ready_o);
    assign cap1    = req1_valid_i && (!pend1_q || res1_ready_o);
    assign pend0_d = cap0 || (pend0_q && !res0_ready_o);
    assign pend1_d = cap1 || (pend1_q && !res1_ready_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            addr0_q <= '0;
            data0_q <= '0;
            rw0_q   <= 1'b0;
            addr1_q <= '0;
            data1_q <= '0;
            rw1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            if (cap0) begin
                addr0_q <= req0_addr_i;
                data0_q <= req0_data_i;
                rw0_q   <= req0_rw_i;
            end
            if (cap1) begin
                addr1_q <= req1_addr_i;
                data1_q <= req1_data_i;
                rw1_q   <= req1_rw_i;
            end
        end
    end

endmodule

// File: tb/tb_mci_arbiter.sv
// Self-checking bench for mci_arbiter: directed vector table, hand sequences, randomized run vs reference model.
// Honours MCI_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mci_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  req0_addr, req1_addr, mem_req_addr;
    logic [127:0] req0_data, req1_data, res0_data, res1_data, mem_req_data, mem_res_data;
    logic         req0_rw, req0_valid, req1_rw, req1_valid;
    logic         res0_ready, res1_ready, mem_req_rw, mem_req_valid, mem_res_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mci_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_addr_i     (req0_addr),
        .req0_data_i     (req0_data),
        .req0_rw_i       (req0_rw),
        .req0_valid_i    (req0_valid),
        .res0_data_o     (res0_data),
        .res0_ready_o    (res0_ready),
        .req1_addr_i     (req1_addr),
        .req1_data_i     (req1_data),
        .req1_rw_i       (req1_rw),
        .req1_valid_i    (req1_valid),
        .res1_data_o     (res1_data),
        .res1_ready_o    (res1_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_data_o  (mem_req_data),
        .mem_req_rw_o    (mem_req_rw),
        .mem_req_valid_o (mem_req_valid),
        .mem_res_data_i  (mem_res_data),
        .mem_res_ready_i (mem_res_ready)
    );

    typedef struct {
        logic         v0;
        logic [31:0]  a0;
        logic         rw0;
        logic         v1;
        logic [31:0]  a1;
        logic         rw1;
        logic         rdy;
        logic [127:0] rdata;
        logic         e_mv;
        logic         e_pay;
        logic [31:0]  e_ma;
        logic         e_mrw;
        logic         e_r0;
        logic         e_r1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req0_valid    = 1'b0;
        req0_addr     = '0;
        req0_data     = '0;
        req0_rw       = 1'b0;
        req1_valid    = 1'b0;
        req1_addr     = '0;
        req1_data     = '0;
        req1_rw       = 1'b0;
        mem_res_ready = 1'b0;
        mem_res_data  = '0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_mvalid"}, mem_req_valid, 1'b0);
        chk({nm, "_r0"}, res0_ready, 1'b0);
        chk({nm, "_r1"}, res1_ready, 1'b0);
        chk({nm, "_d0"}, res0_data, 128'h0);
        chk({nm, "_d1"}, res1_data, 128'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_quiet("reset_hold");
        chk("reset_addr", mem_req_addr, 32'h0);
        chk("reset_data", mem_req_data, 128'h0);
        chk("reset_rw", mem_req_rw, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // reference model: one pending slot per port plus the index of the outstanding port
    logic         m_pend[2];
    logic [31:0]  m_addr[2];
    logic [127:0] m_data[2];
    logic         m_rw[2];
    int           m_out;
    int           m_last;

    function automatic int pick();
`ifdef MCI_ARB_ROUND_ROBIN_EN
        if (m_pend[0] && m_pend[1]) return 1 - m_last;
`endif
        return m_pend[1] ? 1 : 0;
    endfunction

    int exp_g[5];
    logic         rv[2];
    logic [31:0]  ra[2];
    logic [127:0] rd[2];
    logic         rrw[2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
`ifdef MCI_ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1, 0};
`endif

        // single read, stray ready in idle, then contention
        vecs[0]  = '{1'b1, 32'h1230, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'h1230, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1, 32'h1230, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1, 32'h1230, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF,
                     1'b0, 1'b1, 32'h1230, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 128'h5555_AAAA, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 128'h2222_0000_1111, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 128'h3333_0000_4444, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req0_valid    = vecs[i].v0;
            req0_addr     = vecs[i].a0;
            req0_data     = {4{vecs[i].a0}};
            req0_rw       = vecs[i].rw0;
            req1_valid    = vecs[i].v1;
            req1_addr     = vecs[i].a1;
            req1_data     = {4{vecs[i].a1}};
            req1_rw       = vecs[i].rw1;
            mem_res_ready = vecs[i].rdy;
            mem_res_data  = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_mvalid", i), mem_req_valid, vecs[i].e_mv);
            if (vecs[i].e_pay || vecs[i].e_mv) begin
                chk($sformatf("vec%0d_maddr", i), mem_req_addr, vecs[i].e_ma);
                chk($sformatf("vec%0d_mrw", i), mem_req_rw, vecs[i].e_mrw);
                chk($sformatf("vec%0d_mdata", i), mem_req_data, {4{vecs[i].e_ma}});
            end
            chk($sformatf("vec%0d_r0", i), res0_ready, vecs[i].e_r0);
            chk($sformatf("vec%0d_r1", i), res1_ready, vecs[i].e_r1);
            chk($sformatf("vec%0d_d0", i), res0_data, vecs[i].e_r0 ? vecs[i].rdata : 128'h0);
            chk($sformatf("vec%0d_d1", i), res1_data, vecs[i].e_r1 ? vecs[i].rdata : 128'h0);
        end

        // write-back followed by allocate on the same ready cycle
        @(negedge clk);
        clear_inputs();
        req1_valid = 1'b1;
        req1_addr  = 32'h0ABC_0000;
        req1_data  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        req1_rw    = 1'b1;
        #1;
        chk("wb_pulse_mvalid", mem_req_valid, 1'b0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("wb_issue_mvalid", mem_req_valid, 1'b1);
        chk("wb_issue_addr", mem_req_addr, 32'h0ABC_0000);
        chk("wb_issue_data", mem_req_data, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);
        chk("wb_issue_rw", mem_req_rw, 1'b1);
        @(negedge clk);
        #1;
        chk("wb_busy_mvalid", mem_req_valid, 1'b0);
        @(negedge clk);
        mem_res_ready = 1'b1;
        mem_res_data  = 128'h77;
        req1_valid    = 1'b1;
        req1_addr     = 32'h0123_4000;
        req1_rw       = 1'b0;
        #1;
        chk("wb_ready_r1", res1_ready, 1'b1);
        chk("wb_ready_d1", res1_data, 128'h77);
        chk("wb_ready_r0", res0_ready, 1'b0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("alloc_mvalid", mem_req_valid, 1'b1);
        chk("alloc_addr", mem_req_addr, 32'h0123_4000);
        chk("alloc_rw", mem_req_rw, 1'b0);
        @(negedge clk);
        mem_res_ready = 1'b1;
        #1;
        chk("alloc_ready_r1", res1_ready, 1'b1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk_quiet("alloc_done");

        // asynchronous reset while a transaction is outstanding
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = 32'h700;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_issue_mvalid", mem_req_valid, 1'b1);
        @(negedge clk);
        @(negedge clk);
        mem_res_ready = 1'b1;
        mem_res_data  = 128'h99;
        #1;
        chk("rst_pre_r0", res0_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk_quiet("rst_async");
        chk("rst_async_addr", mem_req_addr, 32'h0);
        @(negedge clk);
        #1;
        chk_quiet("rst_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_quiet("rst_stray_ready");
        @(negedge clk);
        clear_inputs();
        #1;
        chk_quiet("rst_no_reissue");
        @(negedge clk);
        #1;
        chk_quiet("rst_no_reissue2");

        // back-to-back contention with re-requests on each ready
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = 32'h400;
        req1_valid = 1'b1;
        req1_addr  = 32'h500;
        for (int r = 0; r < 5; r++) begin
            logic found;
            int   g;
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                @(negedge clk);
                clear_inputs();
                #1;
                if (mem_req_valid) begin
                    found = 1'b1;
                    g     = mem_req_addr[8] ? 1 : 0;
                end
            end
            chk($sformatf("rr_round%0d_issued", r), found, 1'b1);
            chk($sformatf("rr_round%0d_grant", r), g, exp_g[r]);
            @(negedge clk);
            mem_res_ready = 1'b1;
            mem_res_data  = 128'(r + 16);
            if (r < 3) begin
                if (g == 1) begin
                    req1_valid = 1'b1;
                    req1_addr  = 32'h500 + 32'(r + 1);
                end else begin
                    req0_valid = 1'b1;
                    req0_addr  = 32'h400 + 32'(r + 1);
                end
            end
            #1;
            chk($sformatf("rr_round%0d_r0", r), res0_ready, g == 0);
            chk($sformatf("rr_round%0d_r1", r), res1_ready, g == 1);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk_quiet("rr_drained");

        // randomized traffic against the reference model
        do_reset();
        m_pend = '{1'b0, 1'b0};
        m_out  = -1;
        m_last = 0;
        for (int c = 0; c < 400; c++) begin
            int   iw;
            int   pp;
            logic rdy;
            logic er[2];
            @(negedge clk);
            rdy = (m_out >= 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            for (int n = 0; n < 2; n++) begin
                er[n]  = rdy && (m_out == n);
                rv[n]  = (!m_pend[n] || er[n]) && ($urandom_range(0, 9) < 3);
                ra[n]  = $urandom;
                rd[n]  = {$urandom, $urandom, $urandom, $urandom};
                rrw[n] = 1'($urandom_range(0, 1));
            end
            req0_valid    = rv[0];
            req0_addr     = ra[0];
            req0_data     = rd[0];
            req0_rw       = rrw[0];
            req1_valid    = rv[1];
            req1_addr     = ra[1];
            req1_data     = rd[1];
            req1_rw       = rrw[1];
            mem_res_ready = rdy;
            mem_res_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            iw = (m_out < 0 && (m_pend[0] || m_pend[1])) ? pick() : -1;
            pp = (iw >= 0) ? iw : m_out;
            chk("rnd_mvalid", mem_req_valid, iw >= 0);
            if (pp >= 0) begin
                chk("rnd_maddr", mem_req_addr, m_addr[pp]);
                chk("rnd_mdata", mem_req_data, m_data[pp]);
                chk("rnd_mrw", mem_req_rw, m_rw[pp]);
            end
            chk("rnd_r0", res0_ready, er[0]);
            chk("rnd_r1", res1_ready, er[1]);
            chk("rnd_d0", res0_data, er[0] ? mem_res_data : 128'h0);
            chk("rnd_d1", res1_data, er[1] ? mem_res_data : 128'h0);
            for (int n = 0; n < 2; n++) begin
                if (rv[n] && (!m_pend[n] || er[n])) begin
                    m_pend[n] = 1'b1;
                    m_addr[n] = ra[n];
                    m_data[n] = rd[n];
                    m_rw[n]   = rrw[n];
                end else if (er[n]) begin
                    m_pend[n] = 1'b0;
                end
            end
            if (iw >= 0) begin
                m_out  = iw;
                m_last = iw;
            end else if (m_out >= 0 && rdy) begin
                m_out = -1;
            end
        end

        @(negedge clk);
        clear_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
